r5p_soc_reset_ctrl: RTL and testbench
=====================================

# r5p_soc_reset_ctrl

Reset sequencer for the R5P mouse simple SoC on small FPGA boards. It takes a raw asynchronous reset, PLL lock, a board button, a software reset request and a watchdog, and produces one clean, synchronously released, active-high `soc_rst` for `r5p_mouse_soc_simple_top`. It also reports the reason for the last reset. It sits between the board pins/PLL and the SoC instance in each board top.

## Interface
- `DEB_CYC`, default 27000: button debounce window in clk cycles (1 ms at 27 MHz); ≥2
- `HOLD_CYC`, default 16: cycles `soc_rst` stays asserted after all sources go quiet; ≥1
- `WDT_CYC`, default 2**24: watchdog timeout in clk cycles; ≥2
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous assert, active-low (power-on / board reset)
- `pll_lock`  in  1  PLL lock, asynchronous to `clk`, active-high
- `btn`  in  1  raw reset button, asynchronous, active-high, bouncing
- `sw_req`  in  1  software reset request, synchronous single-cycle pulse
- `wdt_en`  in  1  watchdog enable, synchronous level
- `wdt_kick`  in  1  watchdog restart, synchronous pulse
- `soc_rst`  out  1  SoC reset, active-high, deasserted synchronously to `clk`
- `cause`  out  4  one-hot last reset cause `{wdt, sw, btn, por}`, sticky until the next reset entry

## Operation
- Reset values (`rst`=0): state LOCK, `soc_rst`=1, `cause`=4'b0001, synchronizers 0, debounced button 0, all counters 0.
- `pll_lock` and `btn` each pass through a 2-flop synchronizer.
- Debounce: the debounced level changes only after the synchronized `btn` has differed from it for DEB_CYC consecutive cycles. Any agreeing sample clears the counter.
- FSM states:
  - LOCK: `soc_rst`=1. Go to HOLD when synchronized lock is 1.
  - HOLD: `soc_rst`=1. Hold counter increments each cycle. Go to RUN when the counter reaches HOLD_CYC-1 and the debounced button is 0. A held button extends HOLD indefinitely.
  - RUN: `soc_rst`=0. Exit on any event, highest priority first:
    - lock loss → LOCK, `cause`=0001
    - debounced button rising edge → HOLD, `cause`=0010
    - `sw_req` → HOLD, `cause`=0100
    - watchdog expiry → HOLD, `cause`=1000
- Only the highest-priority simultaneous event is recorded in `cause`.
- Lock loss during HOLD returns to LOCK with `cause` unchanged.
- `sw_req`, `wdt_kick` and watchdog events outside RUN are ignored.
- Watchdog counter:
  - Cleared outside RUN, when `wdt_en`=0, or on `wdt_kick`.
  - Otherwise increments in RUN. Expiry is the cycle the count equals WDT_CYC-1 with no kick. A kick in the expiry cycle wins.
- Hold counter clears on every entry to HOLD. Counter widths are `$clog2` of their parameter; none wrap.

## Timing
- `soc_rst` is a direct flop output: `soc_rst` = (state != RUN) as registered. No combinational path from any input.
- From `rst` rising, with `pll_lock`=1 and `btn`=0 steady:
  - sync captures at edge 1 and 2
  - HOLD entered at edge 3
  - `soc_rst` falls after edge 3+HOLD_CYC
- From `sw_req` in RUN: `soc_rst` rises after the next edge and stays high exactly HOLD_CYC cycles.
- From a clean button press: `soc_rst` rises 2+DEB_CYC+1 edges after `btn` rises.
- `cause` updates on the same edge that enters HOLD/LOCK from RUN.
- `rst` low at any time forces all reset values immediately, mid-HOLD or mid-debounce included.

## Structure
- Package `r5p_soc_reset_pkg` holds:
  - state enum `{LOCK, HOLD, RUN}`
  - cause typedef (packed struct `{wdt, sw, btn, por}`)
  - cause constants
- Sub-module `r5p_debounce` contains the 2-flop sync, the debounce counter and a rising-edge pulse output. It is parameterized by DEB_CYC and reusable for the S[2] button.
- The top holds the FSM, hold counter, watchdog counter and `cause` register.

## Test plan
- Power-up, DEB_CYC=4, HOLD_CYC=16: release `rst` with lock=1 → `soc_rst` falls after edge 19, `cause`=0001.
- Lock arrives 100 cycles after `rst` release → `soc_rst` falls 100+2+1+16 edges after release. Drop lock in RUN → `soc_rst`=1 in 3 cycles, `cause`=0001.
- Button glitches of 3 cycles (DEB_CYC=4) → no reset. Clean 40-cycle press → `soc_rst` asserted until button debounced low plus HOLD, `cause`=0010.
- `sw_req` pulse in RUN → `soc_rst` high exactly 16 cycles, `cause`=0100. `sw_req` during HOLD → no extension.
- WDT_CYC=64, `wdt_en`=1, kick every 60 cycles → no reset. Stop kicking → reset 64 cycles after last kick, `cause`=1000. Kick on the expiry cycle → no reset.
- `btn` edge and `sw_req` in the same cycle → `cause`=0010. Assert `rst` mid-HOLD → outputs return to reset values immediately.

Source files
------------

// File: rtl/r5p_soc_reset_pkg.sv
// Shared types and constants for the R5P SoC reset sequencer.
`default_nettype none

package r5p_soc_reset_pkg;

    typedef enum logic [1:0] {
        ST_LOCK = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    typedef struct packed {
        logic wdt;
        logic sw;
        logic btn;
        logic por;
    } cause_t;

    localparam cause_t CAUSE_POR = cause_t'(4'b0001);
    localparam cause_t CAUSE_BTN = cause_t'(4'b0010);
    localparam cause_t CAUSE_SW  = cause_t'(4'b0100);
    localparam cause_t CAUSE_WDT = cause_t'(4'b1000);

    // Counter width for a terminal count of n; never narrower than one bit.
    function automatic int cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/r5p_debounce.sv
// Two-flop synchronizer plus consecutive-sample debouncer with a one-cycle rising pulse.
`default_nettype none

module r5p_debounce
    import r5p_soc_reset_pkg::*;
#(
    parameter int unsigned DEB_CYC = 27000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_width(DEB_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYC - 1);

    logic          sync_meta;
    logic          sync_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta <= 1'b0;
            sync_q    <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
        end else begin
            sync_meta <= din;
            sync_q    <= sync_meta;
            rise      <= 1'b0;
            // Any sample agreeing with the current level restarts the window.
            if (sync_q == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt   <= '0;
                level <= sync_q;
                rise  <= sync_q;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/r5p_soc_reset_ctrl.sv
// Reset sequencer for the R5P mouse SoC: merges PLL lock, button, software and
// watchdog sources into one synchronously released soc_rst and records the cause.
`default_nettype none

module r5p_soc_reset_ctrl
    import r5p_soc_reset_pkg::*;
#(
    parameter int unsigned DEB_CYC  = 27000,
    parameter int unsigned HOLD_CYC = 16,
    parameter int unsigned WDT_CYC  = 2**24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       btn,
    input  logic       sw_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       soc_rst,
    output logic [3:0] cause
);

    localparam int HW = cnt_width(HOLD_CYC);
    localparam int WW = cnt_width(WDT_CYC);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC - 1);
    localparam logic [WW-1:0] WDT_MAX  = WW'(WDT_CYC - 1);

    logic          lock_meta;
    logic          lock_sync;
    logic          btn_level;
    logic          btn_rise;
    state_t        state;
    state_t        state_nxt;
    cause_t        cause_q;
    cause_t        cause_nxt;
    logic [HW-1:0] hold_cnt;
    logic [WW-1:0] wdt_cnt;
    logic          wdt_expire;

    r5p_debounce #(
        .DEB_CYC (DEB_CYC)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .din   (btn),
        .level (btn_level),
        .rise  (btn_rise)
    );

    assign wdt_expire = (state == ST_RUN) && wdt_en && !wdt_kick && (wdt_cnt == WDT_MAX);
    assign cause      = cause_q;

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        case (state)
            ST_LOCK: begin
                if (lock_sync) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!lock_sync) begin
                    state_nxt = ST_LOCK;
                end else if ((hold_cnt == HOLD_MAX) && !btn_level) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_sync) begin
                    state_nxt = ST_LOCK;
                    cause_nxt = CAUSE_POR;
                end else if (btn_rise) begin
                    state_nxt = ST_HOLD;
                    cause_nxt = CAUSE_BTN;
                end else if (sw_req) begin
                    state_nxt = ST_HOLD;
                    cause_nxt = CAUSE_SW;
                end else if (wdt_expire) begin
                    state_nxt = ST_HOLD;
                    cause_nxt = CAUSE_WDT;
                end
            end
            default: begin
                state_nxt = ST_LOCK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
            state     <= ST_LOCK;
            cause_q   <= CAUSE_POR;
            soc_rst   <= 1'b1;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
            state     <= state_nxt;
            cause_q   <= cause_nxt;
            soc_rst   <= (state_nxt != ST_RUN);
        end
    end

    // Saturates so a held button can stretch HOLD without wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
        end else if (state != ST_HOLD) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdt_cnt <= '0;
        end else if ((state != ST_RUN) || !wdt_en || wdt_kick || wdt_expire) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + WW'(1);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_r5p_soc_reset_ctrl.sv
// Self-checking bench for r5p_soc_reset_ctrl: directed scenarios plus random traffic vs. a behavioural model.
`timescale 1ns/1ps
`default_nettype none

module tb_r5p_soc_reset_ctrl;

    localparam int DEB  = 4;
    localparam int HOLD = 16;
    localparam int WDT  = 64;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       pll_lock = 1'b0;
    logic       btn      = 1'b0;
    logic       sw_req   = 1'b0;
    logic       wdt_en   = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       soc_rst;
    logic [3:0] cause;

    int checks = 0;
    int errors = 0;

    r5p_soc_reset_ctrl #(
        .DEB_CYC  (DEB),
        .HOLD_CYC (HOLD),
        .WDT_CYC  (WDT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pll_lock (pll_lock),
        .btn      (btn),
        .sw_req   (sw_req),
        .wdt_en   (wdt_en),
        .wdt_kick (wdt_kick),
        .soc_rst  (soc_rst),
        .cause    (cause)
    );

    always #5 clk = ~clk;

    // Behavioural model. phase: 0 waiting for lock, 1 quiet period, 2 running.
    bit         lk_hist[$];
    bit         bt_hist[$];
    bit         deb_win[$];
    bit         m_db;
    bit         m_rise;
    int         m_phase;
    int         m_quiet;
    int         m_idle;
    logic [3:0] m_cause;
    logic       m_soc_rst;

    function automatic void model_reset();
        lk_hist   = {1'b0, 1'b0};
        bt_hist   = {1'b0, 1'b0};
        deb_win.delete();
        m_db      = 1'b0;
        m_rise    = 1'b0;
        m_phase   = 0;
        m_quiet   = 0;
        m_idle    = 0;
        m_cause   = 4'b0001;
        m_soc_rst = 1'b1;
    endfunction

    function automatic void model_edge(input bit lk, input bit b, input bit sw, input bit en, input bit kick);
        bit lock_s   = lk_hist[0];
        bit btn_s    = bt_hist[0];
        bit lvl      = m_db;
        bit rise_s   = m_rise;
        bit running  = (m_phase == 2);
        bit expire   = running && en && !kick && (m_idle == WDT - 1);
        bit all_diff;
        case (m_phase)
            0: if (lock_s) begin m_phase = 1; m_quiet = 0; end
            1: begin
                if (!lock_s) m_phase = 0;
                else if (m_quiet >= HOLD - 1 && !lvl) m_phase = 2;
                else m_quiet++;
            end
            default: begin
                if (!lock_s)     begin m_phase = 0; m_cause = 4'b0001; end
                else if (rise_s) begin m_phase = 1; m_quiet = 0; m_cause = 4'b0010; end
                else if (sw)     begin m_phase = 1; m_quiet = 0; m_cause = 4'b0100; end
                else if (expire) begin m_phase = 1; m_quiet = 0; m_cause = 4'b1000; end
            end
        endcase
        if (!running || !en || kick || expire) m_idle = 0;
        else m_idle++;
        deb_win.push_back(btn_s);
        if (deb_win.size() > DEB) void'(deb_win.pop_front());
        all_diff = (deb_win.size() == DEB);
        foreach (deb_win[k]) if (deb_win[k] == lvl) all_diff = 1'b0;
        m_rise = 1'b0;
        if (all_diff) begin
            m_db   = !lvl;
            m_rise = !lvl;
            deb_win.delete();
        end
        lk_hist.push_back(lk);
        bt_hist.push_back(b);
        void'(lk_hist.pop_front());
        void'(bt_hist.pop_front());
        m_soc_rst = (m_phase != 2);
    endfunction

    task automatic step(input bit lk, input bit b, input bit sw, input bit en, input bit kick);
        pll_lock = lk;
        btn      = b;
        sw_req   = sw;
        wdt_en   = en;
        wdt_kick = kick;
        @(posedge clk);
        #1;
        model_edge(lk, b, sw, en, kick);
    endtask

    task automatic test_reset();
        int fall = -1;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (soc_rst !== 1'b1 || cause !== 4'b0001) begin
            errors++;
            $display("FAIL reset_state: soc_rst=%b cause=%b, expected 1 0001", soc_rst, cause);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (soc_rst !== m_soc_rst || cause !== m_cause) begin
                errors++;
                $display("FAIL powerup step %0d: soc_rst=%b cause=%b, expected %b %b", i, soc_rst, cause, m_soc_rst, m_cause);
            end
            if (fall < 0 && soc_rst === 1'b0) fall = i;
        end
        checks++;
        if (fall != 3 + HOLD || cause !== 4'b0001) begin
            errors++;
            $display("FAIL powerup_release: edge=%0d cause=%b, expected edge %0d cause 0001", fall, cause, 3 + HOLD);
        end
    endtask

    task automatic test_lock_delay();
        int fall = -1;
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (soc_rst !== 1'b1 || cause !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset_in_run: soc_rst=%b cause=%b, expected 1 0001", soc_rst, cause);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 1; i <= 130; i++) begin
            step(i > 100, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (soc_rst !== m_soc_rst || cause !== m_cause) begin
                errors++;
                $display("FAIL lock_delay step %0d: soc_rst=%b cause=%b, expected %b %b", i, soc_rst, cause, m_soc_rst, m_cause);
            end
            if (fall < 0 && soc_rst === 1'b0) fall = i;
        end
        checks++;
        if (fall != 100 + 2 + 1 + HOLD) begin
            errors++;
            $display("FAIL lock_delay_release: edge=%0d, expected %0d", fall, 100 + 2 + 1 + HOLD);
        end
    endtask

    task automatic test_sw_req();
        for (int pass = 0; pass < 2; pass++) begin
            int high = 0;
            for (int i = 1; i <= 30; i++) begin
                step(1'b1, 1'b0, (i == 1) || (pass == 1 && i == 5), 1'b0, 1'b0);
                checks++;
                if (soc_rst !== m_soc_rst || cause !== m_cause) begin
                    errors++;
                    $display("FAIL sw_req pass %0d step %0d: soc_rst=%b cause=%b, expected %b %b", pass, i, soc_rst, cause, m_soc_rst, m_cause);
                end
                if (soc_rst === 1'b1) high++;
            end
            checks++;
            if (high != HOLD || cause !== 4'b0100) begin
                errors++;
                $display("FAIL sw_req_width pass %0d: high=%0d cause=%b, expected %0d 0100", pass, high, cause, HOLD);
            end
        end
    endtask

    task automatic test_lock_drop();
        for (int i = 1; i <= 28; i++) begin
            step(i > 3, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (soc_rst !== m_soc_rst || cause !== m_cause) begin
                errors++;
                $display("FAIL lock_drop step %0d: soc_rst=%b cause=%b, expected %b %b", i, soc_rst, cause, m_soc_rst, m_cause);
            end
            if (i <= 3) begin
                checks++;
                if (soc_rst !== (i == 3) || (i == 3 && cause !== 4'b0001)) begin
                    errors++;
                    $display("FAIL lock_drop_latency step %0d: soc_rst=%b cause=%b", i, soc_rst, cause);
                end
            end
        end
        checks++;
        if (soc_rst !== 1'b0) begin
            errors++;
            $display("FAIL lock_return: soc_rst=%b, expected 0", soc_rst);
        end
    endtask

    task automatic test_button();
        int high = 0;
        for (int g = 0; g < 3; g++) begin
            for (int i = 1; i <= 8; i++) begin
                step(1'b1, i <= 3, 1'b0, 1'b0, 1'b0);
                checks++;
                if (soc_rst !== 1'b0 || soc_rst !== m_soc_rst) begin
                    errors++;
                    $display("FAIL btn_glitch %0d step %0d: soc_rst=%b, expected 0", g, i, soc_rst);
                end
            end
        end
        for (int i = 1; i <= 60; i++) begin
            step(1'b1, i <= 40, 1'b0, 1'b0, 1'b0);
            checks++;
            if (soc_rst !== m_soc_rst || cause !== m_cause) begin
                errors++;
                $display("FAIL btn_press step %0d: soc_rst=%b cause=%b, expected %b %b", i, soc_rst, cause, m_soc_rst, m_cause);
            end
            if (soc_rst === 1'b1) high++;
            if (i == 2 + DEB || i == 3 + DEB) begin
                checks++;
                if (soc_rst !== (i == 3 + DEB)) begin
                    errors++;
                    $display("FAIL btn_latency step %0d: soc_rst=%b", i, soc_rst);
                end
            end
        end
        checks++;
        if (high != 40 || cause !== 4'b0010) begin
            errors++;
            $display("FAIL btn_press_width: high=%0d cause=%b, expected 40 0010", high, cause);
        end
    endtask

    task automatic test_watchdog();
        int  rise_at = -1;
        bit  found   = 1'b0;
        for (int i = 1; i <= 180; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, (i % 60) == 0);
            checks++;
            if (soc_rst !== 1'b0 || soc_rst !== m_soc_rst) begin
                errors++;
                $display("FAIL wdt_kicked step %0d: soc_rst=%b, expected 0", i, soc_rst);
            end
        end
        for (int j = 1; j <= 70; j++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            checks++;
            if (soc_rst !== m_soc_rst || cause !== m_cause) begin
                errors++;
                $display("FAIL wdt_expire step %0d: soc_rst=%b cause=%b, expected %b %b", j, soc_rst, cause, m_soc_rst, m_cause);
            end
            if (rise_at < 0 && soc_rst === 1'b1) rise_at = j;
        end
        checks++;
        if (rise_at != WDT || cause !== 4'b1000) begin
            errors++;
            $display("FAIL wdt_timeout: edge=%0d cause=%b, expected %0d 1000", rise_at, cause, WDT);
        end
        for (int j = 1; j <= 40 && !found; j++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            if (soc_rst === 1'b0) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wdt_recover: soc_rst=%b, expected 0 within 40 cycles", soc_rst);
        end
        for (int j = 1; j <= 74; j++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, j == WDT);
            checks++;
            if (soc_rst !== 1'b0 || soc_rst !== m_soc_rst) begin
                errors++;
                $display("FAIL wdt_kick_on_expiry step %0d: soc_rst=%b, expected 0", j, soc_rst);
            end
        end
    endtask

    task automatic test_priority();
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, i <= 10, i == 3 + DEB, 1'b0, 1'b0);
            checks++;
            if (soc_rst !== m_soc_rst || cause !== m_cause) begin
                errors++;
                $display("FAIL priority step %0d: soc_rst=%b cause=%b, expected %b %b", i, soc_rst, cause, m_soc_rst, m_cause);
            end
            if (i == 3 + DEB) begin
                checks++;
                if (soc_rst !== 1'b1 || cause !== 4'b0010) begin
                    errors++;
                    $display("FAIL priority_cause: soc_rst=%b cause=%b, expected 1 0010", soc_rst, cause);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, i == 1, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (soc_rst !== 1'b1 || cause !== 4'b0001) begin
            errors++;
            $display("FAIL reset_mid_hold: soc_rst=%b cause=%b, expected 1 0001", soc_rst, cause);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (soc_rst !== m_soc_rst || cause !== m_cause) begin
                errors++;
                $display("FAIL reset_mid_hold_recover step %0d: soc_rst=%b cause=%b, expected %b %b", i, soc_rst, cause, m_soc_rst, m_cause);
            end
        end
    endtask

    task automatic test_random();
        int lk_off  = 0;
        int btn_len = 0;
        bit en      = 1'b1;
        for (int i = 1; i <= 2500; i++) begin
            bit lk, b, sw, kick;
            if (lk_off == 0 && $urandom_range(299) == 0) lk_off = $urandom_range(6, 1);
            if (btn_len == 0 && $urandom_range(39) == 0) btn_len = $urandom_range(12, 1);
            if ($urandom_range(199) == 0) en = !en;
            lk   = (lk_off == 0);
            b    = (btn_len != 0);
            sw   = ($urandom_range(79) == 0);
            kick = ($urandom_range(49) == 0);
            if (lk_off > 0) lk_off--;
            if (btn_len > 0) btn_len--;
            step(lk, b, sw, en, kick);
            checks++;
            if (soc_rst !== m_soc_rst || cause !== m_cause) begin
                errors++;
                $display("FAIL random step %0d: soc_rst=%b cause=%b, expected %b %b", i, soc_rst, cause, m_soc_rst, m_cause);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        #1;
        test_reset();
        test_lock_delay();
        test_sw_req();
        test_lock_drop();
        test_button();
        test_watchdog();
        test_priority();
        test_reset_mid_hold();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
